// File: rtl/perf_tcp_pkg.sv
// Shared types and status codes for the perf_tcp server control path.
package perf_tcp_pkg;

    // Listen sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        HOLD     = 2'd3
    } listen_state_t;

    // Status codes reported in place of a stack response
    localparam logic [7:0] STS_ERR_PORT0   = 8'hFE;
    localparam logic [7:0] STS_ERR_TIMEOUT = 8'hFF;

endpackage : perf_tcp_pkg

// File: rtl/perf_tcp_listen_ctrl.sv
// Listen-port request sequencer: turns a CSR GO pulse into one listen
// request toward the TCP/IP stack, holds the outcome as CSR status until
// the host acknowledges it, and counts ports that opened successfully.
// A request that times out leaves a response in flight; the "stale" flag
// makes sure that late response is swallowed before a new request goes out.
module perf_tcp_listen_ctrl
    import perf_tcp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_BITS       = 32
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic [1:0]          listen_ctrl,
    input  logic [15:0]         listen_port_addr,
    input  logic [1:0]          port_sts_rd,

    output logic                sts_valid,
    output logic [7:0]          sts_data,
    output logic [CNT_BITS-1:0] port_acc_cnt,
    output logic                busy,

    output logic                m_listen_req_valid,
    input  logic                m_listen_req_ready,
    output logic [15:0]         m_listen_req_port,

    input  logic                s_listen_rsp_valid,
    output logic                s_listen_rsp_ready,
    input  logic [7:0]          s_listen_rsp_data
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    listen_state_t    state;
    logic             stale;
    logic [TMO_W-1:0] tmo_cnt;
    logic [15:0]      port_q;

    logic go;
    logic ack;
    logic req_fire;
    logic unused_csr_bits;

    assign go              = listen_ctrl[0];
    assign ack             = port_sts_rd[0];
    assign unused_csr_bits = listen_ctrl[1] ^ port_sts_rd[1];

    // Request is withheld while a stale response is still owed by the stack,
    // so the stack never sees a new request before the old one is retired.
    assign m_listen_req_valid = (state == REQ) && !stale;
    assign m_listen_req_port  = port_q;
    assign req_fire           = m_listen_req_valid && m_listen_req_ready;

    // Accept responses while waiting for one, or while draining a stale one.
    assign s_listen_rsp_ready = (state == WAIT_RSP) || stale;
    assign busy               = (state != IDLE);

    // Sequencer FSM, timeout counter, status registers and success counter.
    // NOTE: every register here is written with <= so all of them update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            stale        <= 1'b0;
            tmo_cnt      <= '0;
            port_q       <= '0;
            sts_valid    <= 1'b0;
            sts_data     <= '0;
            port_acc_cnt <= '0;
        end else begin
            // Late response from an abandoned request: consume and drop it.
            if (stale && s_listen_rsp_valid && (state != WAIT_RSP)) begin
                stale <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (go) begin
                        if (listen_port_addr != 16'd0) begin
                            port_q <= listen_port_addr;
                            state  <= REQ;
                        end else begin
                            sts_data  <= STS_ERR_PORT0;
                            sts_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end

                REQ: begin
                    if (req_fire) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    // A response in the final cycle still beats the timeout.
                    if (s_listen_rsp_valid) begin
                        sts_data  <= s_listen_rsp_data;
                        sts_valid <= 1'b1;
                        if (s_listen_rsp_data[0] && !(&port_acc_cnt)) begin
                            port_acc_cnt <= port_acc_cnt + CNT_BITS'(1);
                        end
                        state <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sts_data  <= STS_ERR_TIMEOUT;
                        sts_valid <= 1'b1;
                        stale     <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                HOLD: begin
                    // sts_data is left in place so the host can re-read it.
                    if (ack) begin
                        sts_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : perf_tcp_listen_ctrl

// File: tb/tb_perf_tcp_listen_ctrl.sv
// Directed self-checking bench for perf_tcp_listen_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_perf_tcp_listen_ctrl;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_BITS       = 8;

    logic                aclk;
    logic                aresetn;
    logic [1:0]          listen_ctrl;
    logic [15:0]         listen_port_addr;
    logic [1:0]          port_sts_rd;
    logic                sts_valid;
    logic [7:0]          sts_data;
    logic [CNT_BITS-1:0] port_acc_cnt;
    logic                busy;
    logic                m_listen_req_valid;
    logic                m_listen_req_ready;
    logic [15:0]         m_listen_req_port;
    logic                s_listen_rsp_valid;
    logic                s_listen_rsp_ready;
    logic [7:0]          s_listen_rsp_data;

    int                  n_checks = 0;
    int                  n_fail   = 0;
    int                  req_count = 0;
    logic [CNT_BITS-1:0] exp_cnt = '0;

    perf_tcp_listen_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_BITS       (CNT_BITS)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .listen_ctrl        (listen_ctrl),
        .listen_port_addr   (listen_port_addr),
        .port_sts_rd        (port_sts_rd),
        .sts_valid          (sts_valid),
        .sts_data           (sts_data),
        .port_acc_cnt       (port_acc_cnt),
        .busy               (busy),
        .m_listen_req_valid (m_listen_req_valid),
        .m_listen_req_ready (m_listen_req_ready),
        .m_listen_req_port  (m_listen_req_port),
        .s_listen_rsp_valid (s_listen_rsp_valid),
        .s_listen_rsp_ready (s_listen_rsp_ready),
        .s_listen_rsp_data  (s_listen_rsp_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count accepted listen requests as seen on the stack side.
    always @(posedge aclk) begin
        if (aresetn && m_listen_req_valid && m_listen_req_ready) req_count++;
    end

    // Hard stop in case a scenario wedges in an unexpected way.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic issue_go(input logic [15:0] port);
        listen_ctrl      = 2'b01;
        listen_port_addr = port;
        tick();
        listen_ctrl      = 2'b00;
    endtask

    task automatic issue_ack();
        port_sts_rd = 2'b01;
        tick();
        port_sts_rd = 2'b00;
    endtask

    // Wait (bounded) for req_valid, hold off ready for 'delay' cycles, then accept.
    task automatic req_handshake(input int delay, input string name);
        int n = 0;
        while (m_listen_req_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (m_listen_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_valid wait: got %b want 1", name, m_listen_req_valid);
        end
        tick(delay);
        m_listen_req_ready = 1'b1;
        tick();
        m_listen_req_ready = 1'b0;
    endtask

    // Present a response and hold it until accepted (bounded).
    task automatic send_rsp(input logic [7:0] d, input string name);
        int n = 0;
        s_listen_rsp_valid = 1'b1;
        s_listen_rsp_data  = d;
        while (s_listen_rsp_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (s_listen_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rsp_ready wait: got %b want 1", name, s_listen_rsp_ready);
        end
        tick();
        s_listen_rsp_valid = 1'b0;
        s_listen_rsp_data  = 8'h00;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({m_listen_req_valid, s_listen_rsp_ready, sts_valid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset flags: got %b want 0000",
                     {m_listen_req_valid, s_listen_rsp_ready, sts_valid, busy});
        end
        n_checks++;
        if (sts_data !== 8'h00 || port_acc_cnt !== 8'h00 || m_listen_req_port !== 16'h0) begin
            n_fail++;
            $display("FAIL reset values: got data=%h cnt=%h port=%h want 00 00 0000",
                     sts_data, port_acc_cnt, m_listen_req_port);
        end
    endtask

    task automatic test_basic_listen();
        int r0 = req_count;
        issue_go(16'd5001);
        n_checks++;
        if (m_listen_req_valid !== 1'b1 || m_listen_req_port !== 16'd5001) begin
            n_fail++;
            $display("FAIL go_latency: got valid=%b port=%0d want 1 5001",
                     m_listen_req_valid, m_listen_req_port);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (m_listen_req_valid !== 1'b1 || m_listen_req_port !== 16'd5001) begin
                n_fail++;
                $display("FAIL req_stable[%0d]: got valid=%b port=%0d want 1 5001",
                         i, m_listen_req_valid, m_listen_req_port);
            end
        end
        m_listen_req_ready = 1'b1;
        tick();
        m_listen_req_ready = 1'b0;
        n_checks++;
        if (m_listen_req_valid !== 1'b0 || s_listen_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_rsp_entry: got req_valid=%b rsp_ready=%b want 0 1",
                     m_listen_req_valid, s_listen_rsp_ready);
        end
        tick(10);
        send_rsp(8'h01, "basic");
        exp_cnt++;
        n_checks++;
        if (sts_valid !== 1'b1 || sts_data !== 8'h01 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL basic_status: got v=%b d=%h cnt=%0d want 1 01 %0d",
                     sts_valid, sts_data, port_acc_cnt, exp_cnt);
        end
        issue_ack();
        n_checks++;
        if (sts_valid !== 1'b0 || busy !== 1'b0 || sts_data !== 8'h01) begin
            n_fail++;
            $display("FAIL basic_ack: got v=%b busy=%b d=%h want 0 0 01",
                     sts_valid, busy, sts_data);
        end
        n_checks++;
        if (req_count - r0 !== 1) begin
            n_fail++;
            $display("FAIL basic_req_count: got %0d want 1", req_count - r0);
        end
    endtask

    task automatic test_rsp_fail_then_ok();
        issue_go(16'd80);
        req_handshake(0, "fail80");
        send_rsp(8'h00, "fail80");
        n_checks++;
        if (sts_valid !== 1'b1 || sts_data !== 8'h00 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL rsp_fail: got v=%b d=%h cnt=%0d want 1 00 %0d",
                     sts_valid, sts_data, port_acc_cnt, exp_cnt);
        end
        issue_ack();
        issue_go(16'd80);
        req_handshake(2, "ok80");
        send_rsp(8'h01, "ok80");
        exp_cnt++;
        n_checks++;
        if (sts_data !== 8'h01 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL rsp_ok: got d=%h cnt=%0d want 01 %0d", sts_data, port_acc_cnt, exp_cnt);
        end
        issue_ack();
    endtask

    task automatic test_port_zero();
        int r0 = req_count;
        issue_go(16'd0);
        n_checks++;
        if (sts_valid !== 1'b1 || sts_data !== 8'hFE || m_listen_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL port0_status: got v=%b d=%h req_valid=%b want 1 fe 0",
                     sts_valid, sts_data, m_listen_req_valid);
        end
        m_listen_req_ready = 1'b1;
        tick(4);
        m_listen_req_ready = 1'b0;
        n_checks++;
        if (m_listen_req_valid !== 1'b0 || busy !== 1'b1 || req_count != r0) begin
            n_fail++;
            $display("FAIL port0_no_req: got req_valid=%b busy=%b reqs=%0d want 0 1 0",
                     m_listen_req_valid, busy, req_count - r0);
        end
        issue_ack();
        n_checks++;
        if (busy !== 1'b0 || sts_valid !== 1'b0 || sts_data !== 8'hFE) begin
            n_fail++;
            $display("FAIL port0_ack: got busy=%b v=%b d=%h want 0 0 fe", busy, sts_valid, sts_data);
        end
    endtask

    task automatic test_timeout_stale();
        // Response in the very last WAIT_RSP cycle must win.
        issue_go(16'd443);
        req_handshake(0, "edge443");
        tick(TIMEOUT_CYCLES - 1);
        s_listen_rsp_valid = 1'b1;
        s_listen_rsp_data  = 8'h01;
        tick();
        s_listen_rsp_valid = 1'b0;
        s_listen_rsp_data  = 8'h00;
        exp_cnt++;
        n_checks++;
        if (sts_data !== 8'h01 || s_listen_rsp_ready !== 1'b0 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL rsp_beats_timeout: got d=%h rsp_ready=%b cnt=%0d want 01 0 %0d",
                     sts_data, s_listen_rsp_ready, port_acc_cnt, exp_cnt);
        end
        issue_ack();

        // No response: timeout reported after the 16th WAIT_RSP cycle.
        issue_go(16'd443);
        req_handshake(0, "tmo443");
        tick(TIMEOUT_CYCLES - 1);
        n_checks++;
        if (sts_valid !== 1'b0 || s_listen_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got v=%b rsp_ready=%b want 0 1", sts_valid, s_listen_rsp_ready);
        end
        tick();
        n_checks++;
        if (sts_valid !== 1'b1 || sts_data !== 8'hFF || s_listen_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_status: got v=%b d=%h rsp_ready=%b want 1 ff 1",
                     sts_valid, sts_data, s_listen_rsp_ready);
        end
        issue_ack();

        // New GO while stale: request held back until the late response drains.
        issue_go(16'd7);
        tick();
        n_checks++;
        if (m_listen_req_valid !== 1'b0 || s_listen_rsp_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_hold: got req_valid=%b rsp_ready=%b busy=%b want 0 1 1",
                     m_listen_req_valid, s_listen_rsp_ready, busy);
        end
        s_listen_rsp_valid = 1'b1;
        s_listen_rsp_data  = 8'h01;
        tick();
        s_listen_rsp_valid = 1'b0;
        s_listen_rsp_data  = 8'h00;
        n_checks++;
        if (m_listen_req_valid !== 1'b1 || m_listen_req_port !== 16'd7 ||
            port_acc_cnt !== exp_cnt || sts_valid !== 1'b0 || sts_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL stale_drop: got req_valid=%b port=%0d cnt=%0d v=%b d=%h want 1 7 %0d 0 ff",
                     m_listen_req_valid, m_listen_req_port, port_acc_cnt, sts_valid, sts_data, exp_cnt);
        end
        req_handshake(0, "after_stale");
        send_rsp(8'h01, "after_stale");
        exp_cnt++;
        n_checks++;
        if (sts_data !== 8'h01 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL after_stale: got d=%h cnt=%0d want 01 %0d", sts_data, port_acc_cnt, exp_cnt);
        end
        issue_ack();
    endtask

    task automatic test_go_while_busy();
        int r0 = req_count;
        issue_go(16'd100);
        req_handshake(1, "busy100");
        issue_go(16'd200);
        n_checks++;
        if (m_listen_req_valid !== 1'b0 || busy !== 1'b1 || m_listen_req_port !== 16'd100) begin
            n_fail++;
            $display("FAIL go_in_wait: got req_valid=%b busy=%b port=%0d want 0 1 100",
                     m_listen_req_valid, busy, m_listen_req_port);
        end
        issue_ack();
        n_checks++;
        if (busy !== 1'b1 || s_listen_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_in_wait: got busy=%b rsp_ready=%b want 1 1", busy, s_listen_rsp_ready);
        end
        send_rsp(8'h01, "busy100");
        exp_cnt++;
        listen_ctrl      = 2'b01;
        listen_port_addr = 16'd300;
        port_sts_rd      = 2'b01;
        tick();
        listen_ctrl = 2'b00;
        port_sts_rd = 2'b00;
        n_checks++;
        if (busy !== 1'b0 || sts_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL go_ack_hold: got busy=%b v=%b want 0 0", busy, sts_valid);
        end
        tick(3);
        n_checks++;
        if (m_listen_req_valid !== 1'b0 || busy !== 1'b0 || m_listen_req_port !== 16'd100 ||
            req_count - r0 !== 1 || port_acc_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL go_dropped: got req_valid=%b busy=%b port=%0d reqs=%0d cnt=%0d want 0 0 100 1 %0d",
                     m_listen_req_valid, busy, m_listen_req_port, req_count - r0, port_acc_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate_and_reset();
        while (exp_cnt != '1) begin
            issue_go(16'd9000);
            req_handshake(0, "fill");
            send_rsp(8'h01, "fill");
            exp_cnt++;
            issue_ack();
        end
        n_checks++;
        if (port_acc_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL cnt_full: got %h want ff", port_acc_cnt);
        end
        issue_go(16'd9001);
        req_handshake(0, "sat");
        send_rsp(8'h01, "sat");
        n_checks++;
        if (port_acc_cnt !== 8'hFF || sts_data !== 8'h01) begin
            n_fail++;
            $display("FAIL cnt_saturate: got cnt=%h d=%h want ff 01", port_acc_cnt, sts_data);
        end
        issue_ack();

        issue_go(16'd9);
        n_checks++;
        if (m_listen_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_req: got %b want 1", m_listen_req_valid);
        end
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({m_listen_req_valid, s_listen_rsp_ready, sts_valid, busy} !== 4'b0000 ||
            sts_data !== 8'h00 || port_acc_cnt !== 8'h00 || m_listen_req_port !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b d=%h cnt=%h port=%h want 0000 00 00 0000",
                     {m_listen_req_valid, s_listen_rsp_ready, sts_valid, busy},
                     sts_data, port_acc_cnt, m_listen_req_port);
        end
        tick(2);
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        aresetn            = 1'b0;
        listen_ctrl        = 2'b00;
        listen_port_addr   = 16'h0;
        port_sts_rd        = 2'b00;
        m_listen_req_ready = 1'b0;
        s_listen_rsp_valid = 1'b0;
        s_listen_rsp_data  = 8'h00;
        #1;
        test_reset();
        tick(2);
        aresetn = 1'b1;
        tick();
        test_reset();

        test_basic_listen();
        test_rsp_fail_then_ok();
        test_port_zero();
        test_timeout_stale();
        test_go_while_busy();
        test_saturate_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_perf_tcp_listen_ctrl
